// File: rtl/reset_sequencer_pkg.sv
// Shared encodings and DC-board defaults for the HDMI-domain reset sequencer.
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    DELAY     = 3'd1,
    WAIT_ACK  = 3'd2,
    RUNNING   = 3'd3,
    FAULT     = 3'd4
  } seq_state_t;

  localparam int DEF_STAGES    = 3;
  localparam int DEF_CNT_WIDTH = 24;

  // Stage 0 sits in the low slice: stage 0 waits 16 cycles, stage 1 waits 8, stage 2 waits 4.
  localparam logic [DEF_STAGES*DEF_CNT_WIDTH-1:0] DEF_DELAYS = {24'd4, 24'd8, 24'd16};
  localparam logic [DEF_STAGES-1:0]               DEF_ACK_MASK    = 3'b011;
  localparam logic [DEF_CNT_WIDTH-1:0]            DEF_ACK_TIMEOUT = 24'd1000;
  localparam logic [7:0]                          DEF_LOCK_FILTER = 8'd4;

endpackage

// File: rtl/reset_sequencer_sync_filter.sv
// Two-flop synchroniser followed by a saturating count of consecutive synchronised-high cycles.
module reset_sequencer_sync_filter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             raw,
  input  logic             clear,
  output logic             synced,
  output logic [WIDTH-1:0] count
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta   <= 1'b0;
      synced <= 1'b0;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

  // Saturate so a long-held lock can never wrap back through the threshold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || !synced) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// N-stage power-up sequencer: filtered PLL lock, per-stage delay, optional ready handshake
// with timeout, fault capture and restart on lock loss or explicit restart pulse.
//
// state     | meaning
// WAIT_LOCK | waiting for the lock filter to reach LOCK_FILTER
// DELAY     | counting down the delay of stage idx
// WAIT_ACK  | stage idx enabled, waiting for its ready (if required)
// RUNNING   | all stages enabled and acked, watching required readies
// FAULT     | a ready timed out or dropped; enables held low
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int                          STAGES      = DEF_STAGES,
  parameter int                          CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter logic [STAGES*CNT_WIDTH-1:0] DELAYS      = DEF_DELAYS,
  parameter logic [STAGES-1:0]           ACK_MASK    = DEF_ACK_MASK,
  parameter logic [CNT_WIDTH-1:0]        ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter logic [7:0]                  LOCK_FILTER = DEF_LOCK_FILTER
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              lock,
  input  logic              restart,
  input  logic [STAGES-1:0] stage_ready,
  output logic [STAGES-1:0] stage_enable,
  output logic              all_ready,
  output logic              fault,
  output logic [2:0]        fault_stage,
  output logic [2:0]        state
);

  localparam logic [CNT_WIDTH-1:0] ACK_LAST = ACK_TIMEOUT - 1'b1;

  seq_state_t           st, st_nx;
  logic [2:0]           idx, idx_nx;
  logic [CNT_WIDTH-1:0] cnt, cnt_nx;
  logic [STAGES-1:0]    en, en_nx;
  logic                 all_rdy, all_rdy_nx;
  logic                 flt, flt_nx;
  logic [2:0]           fs, fs_nx;

  logic                 lock_s;
  logic [7:0]           lock_count;
  logic                 filter_done;

  logic                 cur_ready;
  logic                 cur_mask;
  logic                 last_stage;
  logic [CNT_WIDTH-1:0] next_delay;
  logic                 miss_any;
  logic [2:0]           miss_idx;

  reset_sequencer_sync_filter #(
    .WIDTH(8)
  ) u_lock_filter (
    .clock (clock),
    .reset (reset),
    .raw   (lock),
    .clear (restart),
    .synced(lock_s),
    .count (lock_count)
  );

  assign filter_done = (lock_count >= LOCK_FILTER);
  assign last_stage  = (idx == 3'(STAGES - 1));

  // Per-stage lookups by the running index, plus the lowest required stage whose ready is low.
  always_comb begin
    cur_ready  = 1'b0;
    cur_mask   = 1'b0;
    next_delay = '0;
    miss_any   = 1'b0;
    miss_idx   = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (3'(i) == idx) begin
        cur_ready = stage_ready[i];
        cur_mask  = ACK_MASK[i];
      end
      if (3'(i) == 3'(idx + 3'd1)) begin
        next_delay = DELAYS[i*CNT_WIDTH +: CNT_WIDTH];
      end
    end
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (ACK_MASK[i] && !stage_ready[i]) begin
        miss_any = 1'b1;
        miss_idx = 3'(i);
      end
    end
  end

  always_comb begin
    st_nx      = st;
    idx_nx     = idx;
    cnt_nx     = cnt;
    en_nx      = en;
    all_rdy_nx = all_rdy;
    flt_nx     = flt;
    fs_nx      = fs;
    if (!lock_s || restart) begin
      st_nx      = WAIT_LOCK;
      idx_nx     = '0;
      cnt_nx     = '0;
      en_nx      = '0;
      all_rdy_nx = 1'b0;
      flt_nx     = 1'b0;
    end else begin
      case (st)
        WAIT_LOCK: begin
          if (filter_done) begin
            st_nx  = DELAY;
            idx_nx = '0;
            cnt_nx = DELAYS[0 +: CNT_WIDTH];
          end
        end
        DELAY: begin
          if (cnt == '0) begin
            for (int i = 0; i < STAGES; i++) begin
              if (3'(i) == idx) en_nx[i] = 1'b1;
            end
            st_nx  = WAIT_ACK;
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
        WAIT_ACK: begin
          // A ready seen in the timeout cycle still advances.
          if (!cur_mask || cur_ready) begin
            if (last_stage) begin
              st_nx      = RUNNING;
              all_rdy_nx = 1'b1;
            end else begin
              st_nx  = DELAY;
              idx_nx = idx + 3'd1;
              cnt_nx = next_delay;
            end
          end else if (cnt == ACK_LAST) begin
            st_nx  = FAULT;
            en_nx  = '0;
            flt_nx = 1'b1;
            fs_nx  = idx;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        RUNNING: begin
          if (miss_any) begin
            st_nx      = FAULT;
            en_nx      = '0;
            all_rdy_nx = 1'b0;
            flt_nx     = 1'b1;
            fs_nx      = miss_idx;
          end
        end
        FAULT: begin
          en_nx      = '0;
          all_rdy_nx = 1'b0;
          flt_nx     = 1'b1;
        end
        default: begin
          st_nx = WAIT_LOCK;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st      <= WAIT_LOCK;
      idx     <= '0;
      cnt     <= '0;
      en      <= '0;
      all_rdy <= 1'b0;
      flt     <= 1'b0;
      fs      <= '0;
    end else begin
      st      <= st_nx;
      idx     <= idx_nx;
      cnt     <= cnt_nx;
      en      <= en_nx;
      all_rdy <= all_rdy_nx;
      flt     <= flt_nx;
      fs      <= fs_nx;
    end
  end

  assign stage_enable = en;
  assign all_ready    = all_rdy;
  assign fault        = flt;
  assign fault_stage  = fs;
  assign state        = st;

endmodule
